// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// Module   : trap_controller
// Purpose  : Machine-mode trap controller for the single-issue RV32 core.
//            Detects synchronous exceptions and level interrupts at the
//            commit point. Owns privilege mode and the mstatus, mie, mtvec,
//            mepc, mcause and mtval state, plus a live mip view. Sequences
//            trap entry and mret through a two-state redirect FSM.
// Ports    : i_clk, i_rst_n                     clock, sync active-low reset
//            i_valid, i_PC, i_inst              committing instruction
//            i_exceptionFromInst, i_causeFromInst  upstream exception
//            i_mret                             instruction is mret
//            i_irq[N_IRQ]                       level interrupt requests
//            i_csrWe, i_csrAddr, i_csrWdata     CSR access port
//            o_csrRdata                         combinational CSR read data
//            o_flush                            kill committing instruction
//            o_redirect, o_redirectPC           registered PC redirect
//            o_privMode                         current privilege (U=00, M=11)
// Revision : 1.0  initial release
// ============================================================================
module trap_controller #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     N_IRQ      = 3,
  parameter logic [XLEN-1:0] PROT_LO    = 32'h0,
  parameter logic [XLEN-1:0] PROT_HI    = 32'h1_0000,
  parameter logic [XLEN-1:0] RESET_TVEC = 32'h0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_PC,
  input  logic [31:0]     i_inst,
  input  logic            i_exceptionFromInst,
  input  logic [3:0]      i_causeFromInst,
  input  logic            i_mret,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic            i_csrWe,
  input  logic [11:0]     i_csrAddr,
  input  logic [XLEN-1:0] i_csrWdata,
  output logic [XLEN-1:0] o_csrRdata,
  output logic            o_flush,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirectPC,
  output logic [1:0]      o_privMode
);

  localparam logic [1:0]  PRIV_U      = 2'b00;
  localparam logic [1:0]  PRIV_M      = 2'b11;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Interrupt line k lives at mip/mie bit 3+4k.
  function automatic logic [XLEN-1:0] irq_bits();
    logic [XLEN-1:0] m;
    m = '0;
    for (int k = 0; k < int'(N_IRQ); k++) m[3+4*k] = 1'b1;
    return m;
  endfunction
  localparam logic [XLEN-1:0] IRQ_MASK = irq_bits();

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      priv_q;
  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [1:0]      mstatus_mpp_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, target_q;

  logic [XLEN-1:0] mip, pending, mstatus_view;
  logic            active, is_u;
  logic            exc;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic            irq_take;
  logic [3:0]      irq_code;
  logic            trap, do_mret, flush, csr_wr;
  logic [XLEN-1:0] trap_cause, trap_tval, tvec_base, trap_target;

  always_comb begin
    mip = '0;
    for (int k = 0; k < int'(N_IRQ); k++) mip[3+4*k] = i_irq[k];
  end

  always_comb begin
    mstatus_view        = '0;
    mstatus_view[3]     = mstatus_mie_q;
    mstatus_view[7]     = mstatus_mpie_q;
    mstatus_view[12:11] = mstatus_mpp_q;
  end

  // In REDIRECT the committing slot is dead, so nothing is evaluated.
  assign active  = i_valid && (state_q == S_RUN);
  assign is_u    = (priv_q == PRIV_U);
  assign pending = mip & mie_q;

  // Synchronous exceptions in priority order.
  always_comb begin
    exc       = 1'b0;
    exc_cause = 4'd0;
    exc_tval  = '0;
    if (active) begin
      if (i_PC[1:0] != 2'b00) begin
        exc       = 1'b1;
        exc_cause = 4'd0;
        exc_tval  = i_PC;
      end else if (is_u && (i_PC > PROT_LO) && (i_PC < PROT_HI)) begin
        exc       = 1'b1;
        exc_cause = 4'd1;
        exc_tval  = i_PC;
      end else if (i_mret && is_u) begin
        exc       = 1'b1;
        exc_cause = 4'd2;
        exc_tval  = XLEN'(i_inst);
      end else if (i_exceptionFromInst) begin
        exc = 1'b1;
        // ecall reports the originating mode: 8 + priv gives 8 (U) or 11 (M).
        exc_cause = (i_causeFromInst == 4'd8) ? (4'd8 + {2'b00, priv_q})
                                              : i_causeFromInst;
      end
    end
  end

  // Interrupt priority: external (11) > software (3) > timer (7).
  always_comb begin
    irq_take = active && !exc && (pending != '0) && (is_u || mstatus_mie_q);
    if (pending[11])     irq_code = 4'd11;
    else if (pending[3]) irq_code = 4'd3;
    else                 irq_code = 4'd7;
  end

  assign trap       = exc || irq_take;
  assign do_mret    = active && i_mret && !trap;
  assign flush      = trap || do_mret;
  assign csr_wr     = active && i_csrWe && !trap;
  assign trap_cause = irq_take ? {1'b1, {(XLEN-5){1'b0}}, irq_code}
                               : {{(XLEN-4){1'b0}}, exc_cause};
  assign trap_tval  = irq_take ? '0 : exc_tval;
  assign tvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
  // Vectored mode only offsets interrupts; exceptions always use the base.
  assign trap_target = (irq_take && mtvec_q[0])
                     ? tvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                     : tvec_base;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:      if (flush) state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_RUN;
      default:    state_d = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= S_RUN;
      priv_q         <= PRIV_M;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mstatus_mpp_q  <= PRIV_U;
      mie_q          <= '0;
      mtvec_q        <= RESET_TVEC;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      target_q       <= '0;
    end else begin
      state_q <= state_d;
      if (csr_wr) begin
        case (i_csrAddr)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= i_csrWdata[3];
            mstatus_mpie_q <= i_csrWdata[7];
            // Only the two implemented modes may be stored in MPP.
            if (i_csrWdata[12:11] == PRIV_U || i_csrWdata[12:11] == PRIV_M)
              mstatus_mpp_q <= i_csrWdata[12:11];
          end
          CSR_MIE:    mie_q    <= i_csrWdata & IRQ_MASK;
          CSR_MTVEC:  mtvec_q  <= i_csrWdata;
          CSR_MEPC:   mepc_q   <= {i_csrWdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE: mcause_q <= i_csrWdata;
          CSR_MTVAL:  mtval_q  <= i_csrWdata;
          default: ;
        endcase
      end
      // Placed after the CSR write so mret's mstatus update takes precedence.
      if (trap) begin
        mepc_q         <= {i_PC[XLEN-1:2], 2'b00};
        mcause_q       <= trap_cause;
        mtval_q        <= trap_tval;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
        mstatus_mpp_q  <= priv_q;
        priv_q         <= PRIV_M;
        target_q       <= trap_target;
      end else if (do_mret) begin
        priv_q         <= mstatus_mpp_q;
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
        mstatus_mpp_q  <= PRIV_U;
        target_q       <= mepc_q;
      end
    end
  end

  always_comb begin
    o_csrRdata = '0;
    case (i_csrAddr)
      CSR_MSTATUS: o_csrRdata = mstatus_view;
      CSR_MIE:     o_csrRdata = mie_q;
      CSR_MTVEC:   o_csrRdata = mtvec_q;
      CSR_MEPC:    o_csrRdata = mepc_q;
      CSR_MCAUSE:  o_csrRdata = mcause_q;
      CSR_MTVAL:   o_csrRdata = mtval_q;
      CSR_MIP:     o_csrRdata = mip;
      default:     o_csrRdata = '0;
    endcase
  end

  assign o_flush      = flush;
  assign o_redirect   = (state_q == S_REDIRECT);
  assign o_redirectPC = target_q;
  assign o_privMode   = priv_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_controller
// Purpose  : Self-checking bench for trap_controller. Directed scenarios
//            followed by random commits, each cycle compared against a
//            behavioural model of the trap/CSR rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_trap_controller;

  localparam logic [31:0] PROT_LO = 32'h0;
  localparam logic [31:0] PROT_HI = 32'h1_0000;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343;
  localparam logic [11:0] A_MIP = 12'h344;

  logic        clk = 1'b0;
  logic        rst_n, valid, exc, mret, we;
  logic [31:0] pc, inst, wdata;
  logic [3:0]  cause_in;
  logic [2:0]  irq;
  logic [11:0] addr;
  logic [31:0] rdata, rpc;
  logic        flush, redirect;
  logic [1:0]  priv;

  always #5 clk = ~clk;

  trap_controller dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_PC(pc), .i_inst(inst),
    .i_exceptionFromInst(exc), .i_causeFromInst(cause_in), .i_mret(mret),
    .i_irq(irq), .i_csrWe(we), .i_csrAddr(addr), .i_csrWdata(wdata),
    .o_csrRdata(rdata), .o_flush(flush), .o_redirect(redirect),
    .o_redirectPC(rpc), .o_privMode(priv)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [1:0]  m_priv, m_mpp;
  logic        m_MIE, m_MPIE, m_redir;
  logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_target;

  // Outputs seen in the most recent cycle, for directed literal checks.
  logic [31:0] obs_rdata, obs_rpc;
  logic        obs_flush, obs_redirect;
  logic [1:0]  obs_priv;

  logic [11:0] addr_tab [9];
  initial addr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                       12'h343, 12'h344, 12'h000, 12'h7C0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_priv = 2'b11; m_mpp = 2'b00; m_MIE = 1'b0; m_MPIE = 1'b0; m_redir = 1'b0;
    m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_target = 0;
  endtask

  function automatic logic [31:0] m_mip();
    logic [31:0] v = 0;
    for (int k = 0; k < 3; k++) if (irq[k]) v = v | (32'h1 << (3 + 4 * k));
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      A_MSTATUS: return {19'd0, m_mpp, 3'd0, m_MPIE, 3'd0, m_MIE, 3'd0};
      A_MIE:     return m_mie;
      A_MTVEC:   return m_mtvec;
      A_MEPC:    return m_mepc;
      A_MCAUSE:  return m_mcause;
      A_MTVAL:   return m_mtval;
      A_MIP:     return m_mip();
      default:   return 32'h0;
    endcase
  endfunction

  // One clock: check outputs against the model at the falling edge, then
  // advance the model by the rules for the rising edge.
  task automatic cycle();
    logic        trap, is_irq, do_mret, found;
    logic [31:0] cz, tval, pend;
    logic [3:0]  code;
    int          prio [3];
    prio = '{11, 3, 7};
    trap = 0; is_irq = 0; do_mret = 0; cz = 0; tval = 0; code = 0; found = 0;
    @(negedge clk);
    if (!m_redir && valid) begin
      if (pc[1:0] != 2'b00) begin
        trap = 1; cz = 0; tval = pc;
      end else if (m_priv == 2'b00 && pc > PROT_LO && pc < PROT_HI) begin
        trap = 1; cz = 1; tval = pc;
      end else if (mret && m_priv == 2'b00) begin
        trap = 1; cz = 2; tval = inst;
      end else if (exc) begin
        trap = 1; tval = 0;
        cz = (cause_in == 4'd8) ? ((m_priv == 2'b00) ? 32'd8 : 32'd11) : {28'd0, cause_in};
      end
      if (!trap) begin
        pend = m_mip() & m_mie;
        if (pend != 0 && (m_priv == 2'b00 || m_MIE)) begin
          trap = 1; is_irq = 1; tval = 0;
          for (int i = 0; i < 3; i++)
            if (!found && pend[prio[i]]) begin found = 1; code = 4'(prio[i]); end
          cz = 32'h8000_0000 | {28'd0, code};
        end
      end
      if (!trap && mret) do_mret = 1;
    end
    chk("flush", 32'(flush), 32'(trap | do_mret));
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("redirectPC", rpc, m_target);
    chk("privMode", 32'(priv), 32'(m_priv));
    chk("csrRdata", rdata, m_read(addr));
    obs_rdata = rdata; obs_rpc = rpc; obs_flush = flush;
    obs_redirect = redirect; obs_priv = priv;
    if (!rst_n) m_reset();
    else if (m_redir) m_redir = 0;
    else begin
      if (valid && we && !trap) begin
        case (addr)
          A_MSTATUS: begin
            m_MIE = wdata[3]; m_MPIE = wdata[7];
            if (wdata[12:11] == 2'b00 || wdata[12:11] == 2'b11) m_mpp = wdata[12:11];
          end
          A_MIE:    m_mie = wdata & 32'h888;
          A_MTVEC:  m_mtvec = wdata;
          A_MEPC:   m_mepc = wdata & ~32'h3;
          A_MCAUSE: m_mcause = wdata;
          A_MTVAL:  m_mtval = wdata;
          default: ;
        endcase
      end
      if (trap) begin
        m_mepc = pc & ~32'h3; m_mcause = cz; m_mtval = tval;
        m_MPIE = m_MIE; m_MIE = 0; m_mpp = m_priv; m_priv = 2'b11;
        m_target = {m_mtvec[31:2], 2'b00} +
                   ((is_irq && m_mtvec[0]) ? {26'd0, code, 2'b00} : 32'd0);
        m_redir = 1;
      end else if (do_mret) begin
        m_priv = m_mpp; m_MIE = m_MPIE; m_MPIE = 1; m_mpp = 2'b00;
        m_target = m_mepc; m_redir = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] p, input logic [31:0] ins, input logic e,
                        input logic [3:0] c, input logic mr, input logic w,
                        input logic [11:0] a, input logic [31:0] wd);
    valid = 1; pc = p; inst = ins; exc = e; cause_in = c; mret = mr;
    we = w; addr = a; wdata = wd;
    cycle();
  endtask

  task automatic idle(input logic [11:0] a);
    valid = 0; exc = 0; mret = 0; we = 0; addr = a;
    cycle();
  endtask

  initial begin
    rst_n = 0; valid = 0; pc = 0; inst = 0; exc = 0; cause_in = 0; mret = 0;
    irq = 0; we = 0; addr = 0; wdata = 0;
    @(posedge clk); #1;
    m_reset();
    idle(A_MTVEC);
    rst_n = 1;

    // Reset state
    idle(A_MSTATUS);
    chk("reset_mstatus", obs_rdata, 32'h0);
    chk("reset_priv", 32'(obs_priv), 32'h3);
    chk("reset_redirect", 32'(obs_redirect), 32'h0);
    chk("reset_rpc", obs_rpc, 32'h0);

    // Drop to U via mret (MPP=00), then fetch inside the protected window.
    commit(32'h40, 32'h3020_0073, 0, 0, 1, 0, 12'h0, 0);
    chk("mret_flush", 32'(obs_flush), 32'h1);
    idle(12'h0);
    chk("mret_redirect", 32'(obs_redirect), 32'h1);
    chk("mret_priv_u", 32'(obs_priv), 32'h0);
    commit(32'h8000, 32'h13, 0, 0, 0, 0, 12'h0, 0);
    chk("fault_flush", 32'(obs_flush), 32'h1);
    idle(A_MCAUSE);
    chk("fault_redirect", 32'(obs_redirect), 32'h1);
    chk("fault_target", obs_rpc, 32'h0);
    chk("fault_mcause", obs_rdata, 32'h1);
    chk("fault_priv", 32'(obs_priv), 32'h3);
    idle(A_MTVAL);
    chk("fault_mtval", obs_rdata, 32'h8000);
    chk("fault_one_redirect", 32'(obs_redirect), 32'h0);
    idle(A_MSTATUS);
    chk("fault_mstatus", obs_rdata, 32'h0);

    // M-mode ecall then mret
    commit(32'h100, 32'h13, 0, 0, 0, 1, A_MTVEC, 32'h200);
    commit(32'h100, 32'h73, 1, 4'd8, 0, 0, 12'h0, 0);
    chk("ecall_flush", 32'(obs_flush), 32'h1);
    idle(A_MCAUSE);
    chk("ecall_mcause", obs_rdata, 32'd11);
    chk("ecall_target", obs_rpc, 32'h200);
    idle(A_MEPC);
    chk("ecall_mepc", obs_rdata, 32'h100);
    commit(32'h200, 32'h3020_0073, 0, 0, 1, 0, 12'h0, 0);
    idle(A_MSTATUS);
    chk("ret_target", obs_rpc, 32'h100);
    chk("ret_priv", 32'(obs_priv), 32'h3);
    chk("ret_mstatus", obs_rdata, 32'h80);

    // Vectored external interrupt
    commit(32'h104, 32'h13, 0, 0, 0, 1, A_MTVEC, 32'h201);
    commit(32'h108, 32'h13, 0, 0, 0, 1, A_MIE, 32'hFFFF_FFFF);
    idle(A_MIE);
    chk("mie_masked", obs_rdata, 32'h888);
    commit(32'h108, 32'h13, 0, 0, 0, 1, A_MIE, 32'h880);
    commit(32'h10C, 32'h13, 0, 0, 0, 1, A_MSTATUS, 32'h8);
    irq = 3'b101;
    commit(32'h300, 32'h13, 0, 0, 0, 0, 12'h0, 0);
    chk("irq_flush", 32'(obs_flush), 32'h1);
    idle(A_MCAUSE);
    chk("irq_mcause", obs_rdata, 32'h8000_000B);
    chk("irq_target", obs_rpc, 32'h22C);
    chk("irq_no_flush_redirect", 32'(obs_flush), 32'h0);
    irq = 3'b000;
    idle(A_MEPC);
    chk("irq_mepc", obs_rdata, 32'h300);
    idle(A_MSTATUS);
    chk("irq_mstatus", obs_rdata, 32'h1880);
    irq = 3'b010;
    idle(A_MIP);
    chk("mip_view", obs_rdata, 32'h80);
    irq = 3'b000;

    // Misaligned beats upstream exception; same-cycle CSR write dropped.
    commit(32'h102, 32'h13, 1, 4'd2, 0, 1, A_MTVEC, 32'hDEAD_0000);
    chk("misalign_flush", 32'(obs_flush), 32'h1);
    idle(A_MCAUSE);
    chk("misalign_mcause", obs_rdata, 32'h0);
    idle(A_MTVAL);
    chk("misalign_mtval", obs_rdata, 32'h102);
    idle(A_MTVEC);
    chk("dropped_write", obs_rdata, 32'h201);

    // mret in U mode, then reset during REDIRECT.
    commit(32'h110, 32'h13, 0, 0, 0, 1, A_MSTATUS, 32'h0);
    commit(32'h114, 32'h3020_0073, 0, 0, 1, 0, 12'h0, 0);
    idle(12'h0);
    chk("to_u_priv", 32'(obs_priv), 32'h0);
    commit(32'h2_0000, 32'h3020_0073, 0, 0, 1, 0, 12'h0, 0);
    chk("umret_flush", 32'(obs_flush), 32'h1);
    rst_n = 0;
    idle(A_MTVAL);
    chk("umret_mtval", obs_rdata, 32'h3020_0073);
    chk("umret_redirect", 32'(obs_redirect), 32'h1);
    rst_n = 1;
    idle(A_MTVEC);
    chk("rst_no_redirect", 32'(obs_redirect), 32'h0);
    chk("rst_mtvec", obs_rdata, 32'h0);
    chk("rst_rpc", obs_rpc, 32'h0);
    idle(A_MCAUSE);
    chk("rst_mcause", obs_rdata, 32'h0);

    // Random commits against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom % 8);
      valid = ($urandom % 4) != 0;
      case (r)
        0: pc = $urandom | 32'h1;
        1, 2: pc = ($urandom % 32'h1_0000) & ~32'h3;
        3: pc = PROT_HI;
        4: pc = PROT_LO;
        default: pc = $urandom & ~32'h3;
      endcase
      inst = $urandom;
      exc = ($urandom % 8) == 0;
      cause_in = 4'($urandom);
      mret = ($urandom % 6) == 0;
      we = !mret && (($urandom % 3) == 0);
      addr = addr_tab[$urandom % 9];
      wdata = $urandom;
      irq = 3'($urandom);
      rst_n = ($urandom % 100) != 0;
      cycle();
    end
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
